// File: rtl/key_event_arbiter.sv
// Key press arbiter: per-key pending bits, a round-robin grant into a 4-entry
// event FIFO, and a registered overflow pulse when a press hits an already-pending key.

module key_pend_cell (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic flag,
  input  logic gnt,
  output logic pend,
  output logic drop
);
  // A grant and a fresh press in the same cycle keep the bit set for the new press
  assign drop = flag & pend & ~gnt;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) pend <= 1'b0;
    else          pend <= flag | (pend & ~gnt);
  end
endmodule

module key_event_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic [3:0] key_flag,
  output logic [1:0] evt_code,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       overflow,
  output logic [2:0] fifo_cnt
);
  localparam int NUM_KEYS = 4;

  logic [NUM_KEYS-1:0] pend, drop, gnt_vec;
  logic [1:0]          rr_ptr, wr_ptr, rd_ptr, gnt_idx, srch_idx;
  logic                gnt_vld, push, pop, full;
  logic [1:0]          mem [FIFO_DEPTH];

  // Full comes from the registered count only: a same-cycle pop never frees a slot
  assign full = (fifo_cnt == 3'(FIFO_DEPTH));

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = rr_ptr;
    srch_idx = rr_ptr;
    for (int i = 0; i < NUM_KEYS; i++) begin
      srch_idx = rr_ptr + 2'(i);
      if (!gnt_vld && pend[srch_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = srch_idx;
      end
    end
    if (full) gnt_vld = 1'b0;
    gnt_vec = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_pend_cell u_cell (
      .sclk    (sclk),
      .s_rst_n (s_rst_n),
      .flag    (key_flag[k]),
      .gnt     (gnt_vec[k]),
      .pend    (pend[k]),
      .drop    (drop[k])
    );
  end

  assign push      = gnt_vld;
  assign evt_valid = (fifo_cnt != 3'd0);
  assign pop       = evt_valid & evt_ready;
  assign evt_code  = mem[rd_ptr];

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rr_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
      overflow <= 1'b0;
    end else begin
      overflow <= |drop;
      if (push) begin
        rr_ptr <= gnt_idx + 2'd1;
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset; contents are only observed while evt_valid is high
  always_ff @(posedge sclk) begin
    if (push) mem[wr_ptr] <= gnt_idx;
  end
endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter: a per-cycle vector table plus
// hand-written drop and mid-stream reset sequences.

module tb_key_event_arbiter;
  logic       sclk = 1'b0;
  logic       s_rst_n = 1'b0;
  logic [3:0] key_flag = 4'b0;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_code;
  logic       evt_valid;
  logic       overflow;
  logic [2:0] fifo_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  key_event_arbiter dut (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .key_flag  (key_flag),
    .evt_code  (evt_code),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .overflow  (overflow),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    bit       do_rst;
    bit [3:0] kf;
    bit       rdy;
    bit       ev;
    bit [1:0] ec;
    bit [2:0] cnt;
    bit       ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, bit [3:0] kf, bit rdy, bit ev, bit [1:0] ec,
                              bit [2:0] cnt, bit ovf);
    vec_t v;
    v.do_rst = r; v.kf = kf; v.rdy = rdy; v.ev = ev; v.ec = ec; v.cnt = cnt; v.ovf = ovf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle; sampling point is 1ns after the rising edge
  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic do_reset();
    key_flag  = 4'b0;
    evt_ready = 1'b0;
    s_rst_n   = 1'b0;
    step();
    s_rst_n   = 1'b1;
  endtask

  int   codes[$];
  int   exp_codes[5] = '{0, 1, 2, 3, 2};
  int   ovf_seen;

  initial begin
    // single press
    add(0, 4'b0100, 1, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 1, 2, 1, 0);
    add(0, 4'b0000, 1, 0, 0, 0, 0);
    // simultaneous press after reset, twice
    add(1, 4'b1111, 1, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 1, 0, 1, 0);
    add(0, 4'b0000, 1, 1, 1, 1, 0);
    add(0, 4'b0000, 1, 1, 2, 1, 0);
    add(0, 4'b0000, 1, 1, 3, 1, 0);
    add(0, 4'b1111, 1, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 1, 0, 1, 0);
    add(0, 4'b0000, 1, 1, 1, 1, 0);
    add(0, 4'b0000, 1, 1, 2, 1, 0);
    add(0, 4'b0000, 1, 1, 3, 1, 0);
    add(0, 4'b0000, 1, 0, 0, 0, 0);
    // round robin: key 1 alone leaves rr_ptr=2, so 0011 yields 0 then 1
    add(0, 4'b0010, 1, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 0, 0, 0, 0);
    add(0, 4'b0011, 1, 1, 1, 1, 0);
    add(0, 4'b0000, 1, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 1, 0, 1, 0);
    add(0, 4'b0000, 1, 1, 1, 1, 0);
    add(0, 4'b0000, 1, 0, 0, 0, 0);
    // full FIFO: fifth press waits in pend, then drains without overflow
    add(1, 4'b0001, 0, 0, 0, 0, 0);
    add(0, 4'b0010, 0, 0, 0, 0, 0);
    add(0, 4'b0100, 0, 1, 0, 1, 0);
    add(0, 4'b1000, 0, 1, 0, 2, 0);
    add(0, 4'b0001, 0, 1, 0, 3, 0);
    add(0, 4'b0000, 0, 1, 0, 4, 0);
    add(0, 4'b0000, 0, 1, 0, 4, 0);
    add(0, 4'b0000, 1, 1, 0, 4, 0);
    add(0, 4'b0000, 1, 1, 1, 3, 0);
    add(0, 4'b0000, 1, 1, 2, 3, 0);
    add(0, 4'b0000, 1, 1, 3, 2, 0);
    add(0, 4'b0000, 1, 1, 0, 1, 0);
    add(0, 4'b0000, 1, 0, 0, 0, 0);

    do_reset();
    chk("rst_valid", evt_valid, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_ovf", overflow, 0);

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      key_flag  = vecs[i].kf;
      evt_ready = vecs[i].rdy;
      chk($sformatf("v%0d_valid", i), evt_valid, vecs[i].ev);
      chk($sformatf("v%0d_cnt", i), fifo_cnt, vecs[i].cnt);
      chk($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
      if (vecs[i].ev) chk($sformatf("v%0d_code", i), evt_code, vecs[i].ec);
      step();
    end

    // drop: FIFO full, key 2 pressed at t5 and again at t25
    do_reset();
    ovf_seen = 0;
    for (int t = 0; t < 40; t++) begin
      case (t)
        0: key_flag = 4'b0001;
        1: key_flag = 4'b0010;
        2: key_flag = 4'b0100;
        3: key_flag = 4'b1000;
        5, 25: key_flag = 4'b0100;
        default: key_flag = 4'b0000;
      endcase
      if (t >= 6) chk($sformatf("drop_ovf_t%0d", t), overflow, (t == 26) ? 1 : 0);
      if (overflow) ovf_seen++;
      if (t == 20) chk("drop_full_cnt", fifo_cnt, 4);
      step();
    end
    chk("drop_ovf_pulses", ovf_seen, 1);
    key_flag  = 4'b0;
    evt_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      if (evt_valid) codes.push_back(int'(evt_code));
      chk($sformatf("drain_ovf_t%0d", t), overflow, 0);
      step();
    end
    chk("drain_len", codes.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("drain_code%0d", i), (i < codes.size()) ? codes[i] : -1, exp_codes[i]);

    // reset mid-stream: three stored, key 3 still pending
    do_reset();
    key_flag = 4'b1111;
    step();
    key_flag = 4'b0000;
    step(); step(); step();
    chk("mid_pre_cnt", fifo_cnt, 3);
    #2 s_rst_n = 1'b0;
    #1;
    chk("mid_async_valid", evt_valid, 0);
    chk("mid_async_cnt", fifo_cnt, 0);
    step();
    chk("mid_held_cnt", fifo_cnt, 0);
    s_rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      step();
      chk($sformatf("mid_post_valid_t%0d", t), evt_valid, 0);
      chk($sformatf("mid_post_cnt_t%0d", t), fifo_cnt, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
